// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared bus widths, field offsets and load-op encodings for the MEM stage
package mem_stage_pkg;

    localparam int ES_MS_BUS_W = 213;
    localparam int MS_WS_BUS_W = 180;
    localparam int EXC_W       = 16;
    localparam int CSR_W       = 94;
    localparam int LD_OP_W     = 5;

    // es_to_ms_bus layout (LSB first)
    localparam int ES_PC_LSB       = 0;
    localparam int ES_RESULT_LSB   = 32;
    localparam int ES_DEST_LSB     = 64;
    localparam int ES_GR_WE        = 69;
    localparam int ES_RES_FROM_MEM = 70;
    localparam int ES_LD_OP_LSB    = 71;
    localparam int ES_IS_REQ       = 76;
    localparam int ES_ERTN         = 77;
    localparam int ES_EXC_LSB      = 78;
    localparam int ES_CSR_LSB      = 94;
    localparam int ES_RSVD_LSB     = 188;

    // ms_to_ws_bus layout (LSB first)
    localparam int MS_PC_LSB     = 0;
    localparam int MS_RESULT_LSB = 32;
    localparam int MS_DEST_LSB   = 64;
    localparam int MS_GR_WE      = 69;
    localparam int MS_CSR_LSB    = 70;
    localparam int MS_EXC_LSB    = 164;

    // ld_op bit positions
    localparam int LD_B  = 0;
    localparam int LD_BU = 1;
    localparam int LD_H  = 2;
    localparam int LD_HU = 3;
    localparam int LD_W  = 4;

    localparam int EXC_ALE = 9;

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - extracts and extends load data by op and low address bits
module mem_load_align
    import mem_stage_pkg::*;
(
    input  logic [LD_OP_W-1:0] ld_op,
    input  logic [1:0]         addr,
    input  logic [31:0]        rdata,
    output logic [31:0]        data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = 32'h0;
        if (ld_op[LD_W])
            data = rdata;
        else if (ld_op[LD_B])
            data = {{24{byte_sel[7]}}, byte_sel};
        else if (ld_op[LD_BU])
            data = {24'h0, byte_sel};
        else if (ld_op[LD_H])
            data = {{16{half_sel[15]}}, half_sel};
        else if (ld_op[LD_HU])
            data = {16'h0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: load response handling, flush cancel and WB/bypass buses
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ES_MS_W = ES_MS_BUS_W,
    parameter int MS_WS_W = MS_WS_BUS_W
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               ws_allowin,
    output logic               ms_allowin,
    input  logic               es_to_ms_valid,
    input  logic [ES_MS_W-1:0] es_to_ms_bus,
    output logic               ms_to_ws_valid,
    output logic [MS_WS_W-1:0] ms_to_ws_bus,
    input  logic               data_sram_data_ok,
    input  logic [31:0]        data_sram_rdata,
    input  logic               wb_ex,
    input  logic               wb_ertn,
    output logic               mem_ex,
    output logic               mem_ertn,
    output logic [38:0]        ms_fwd_bus
);

    logic [ES_MS_W-1:0] payload;
    logic               ms_valid;
    logic               cancel;
    logic               data_ok_seen;
    logic [31:0]        rdata_buf;
    logic               ms_ready_go;
    logic               flush;

    logic [31:0]        pc;
    logic [31:0]        result;
    logic [4:0]         dest;
    logic               gr_we;
    logic               res_from_mem;
    logic [LD_OP_W-1:0] ld_op;
    logic               is_req;
    logic               ertn;
    logic [EXC_W-1:0]   exc;
    logic [CSR_W-1:0]   csr;
    logic [ES_MS_W-ES_RSVD_LSB-1:0] unused_rsvd;

    logic [31:0]        load_src;
    logic [31:0]        load_data;
    logic [31:0]        final_result;
    logic               ws_gr_we;

    assign pc           = payload[ES_PC_LSB +: 32];
    assign result       = payload[ES_RESULT_LSB +: 32];
    assign dest         = payload[ES_DEST_LSB +: 5];
    assign gr_we        = payload[ES_GR_WE];
    assign res_from_mem = payload[ES_RES_FROM_MEM];
    assign ld_op        = payload[ES_LD_OP_LSB +: LD_OP_W];
    assign is_req       = payload[ES_IS_REQ];
    assign ertn         = payload[ES_ERTN];
    assign exc          = payload[ES_EXC_LSB +: EXC_W];
    assign csr          = payload[ES_CSR_LSB +: CSR_W];
    assign unused_rsvd  = payload[ES_MS_W-1:ES_RSVD_LSB];

    assign flush          = wb_ex | wb_ertn;
    assign ms_ready_go    = !cancel && (!is_req || data_ok_seen || data_sram_data_ok);
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    // Payload holds no reset: ms_valid alone qualifies its contents.
    always_ff @(posedge clk) begin
        if (es_to_ms_valid && ms_allowin)
            payload <= es_to_ms_bus;
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            ms_valid <= 1'b0;
        else if (flush)
            ms_valid <= 1'b0;
        else if (ms_allowin)
            ms_valid <= es_to_ms_valid;
    end

    // A flushed load still has its response in flight; swallow it when it returns.
    always_ff @(posedge clk) begin
        if (!resetn)
            cancel <= 1'b0;
        else if (cancel) begin
            if (data_sram_data_ok)
                cancel <= 1'b0;
        end else if (flush && ms_valid && is_req && !data_ok_seen && !data_sram_data_ok)
            cancel <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            data_ok_seen <= 1'b0;
            rdata_buf    <= 32'h0;
        end else if (flush || (ms_to_ws_valid && ws_allowin)) begin
            data_ok_seen <= 1'b0;
        end else if (ms_valid && is_req && !cancel && data_sram_data_ok && !ws_allowin) begin
            data_ok_seen <= 1'b1;
            rdata_buf    <= data_sram_rdata;
        end
    end

    assign load_src = data_ok_seen ? rdata_buf : data_sram_rdata;

    mem_load_align u_load_align (
        .ld_op (ld_op),
        .addr  (result[1:0]),
        .rdata (load_src),
        .data  (load_data)
    );

    assign final_result = res_from_mem ? load_data : result;
    assign ws_gr_we     = gr_we && !(|exc);

    assign ms_to_ws_bus = {exc, csr, ws_gr_we, dest, final_result, pc};

    assign mem_ex   = ms_valid && (|exc);
    assign mem_ertn = ms_valid && ertn;

    assign ms_fwd_bus = {ms_valid && gr_we,
                         ms_valid && res_from_mem && !ms_ready_go,
                         dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [212:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [179:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_ex;
    logic         wb_ertn;
    logic         mem_ex;
    logic         mem_ertn;
    logic [38:0]  ms_fwd_bus;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_ex             (wb_ex),
        .wb_ertn           (wb_ertn),
        .mem_ex            (mem_ex),
        .mem_ertn          (mem_ertn),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [212:0] mk_bus(input logic [4:0] ld_op, input logic is_req,
                                            input logic rfm, input logic gr_we,
                                            input logic [4:0] dest, input logic [31:0] result,
                                            input logic [15:0] exc, input logic ertn,
                                            input logic [31:0] pc);
        logic [212:0] b;
        b = '0;
        b[31:0]    = pc;
        b[63:32]   = result;
        b[68:64]   = dest;
        b[69]      = gr_we;
        b[70]      = rfm;
        b[75:71]   = ld_op;
        b[76]      = is_req;
        b[77]      = ertn;
        b[93:78]   = exc;
        return b;
    endfunction

    // Advance one cycle; inputs are changed and outputs checked around the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check_vec({tag, "_valid"},  {63'h0, ms_to_ws_valid}, 64'h0);
        check_vec({tag, "_allowin"}, {63'h0, ms_allowin},    64'h1);
        check_vec({tag, "_ex"},     {62'h0, mem_ex, mem_ertn}, 64'h0);
        check_vec({tag, "_fwd"},    {62'h0, ms_fwd_bus[38:37]}, 64'h0);
    endtask

    initial begin
        resetn = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; wb_ex = 1'b0; wb_ertn = 1'b0;
        @(negedge clk);
        tick();
        #1 check_idle("reset");
        resetn = 1'b1;
        tick();
        #1 check_idle("post_reset");

        // non-memory add
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'h1234, 16'h0, 1'b0, 32'h100);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check_vec("add_valid", {63'h0, ms_to_ws_valid}, 64'h1);
        check_vec("add_fwd", {25'h0, ms_fwd_bus}, {25'h0, 1'b1, 1'b0, 5'd5, 32'h1234});
        check_vec("add_ws", {30'h0, ms_to_ws_bus[69:32]}, {30'h0, 1'b1, 5'd5, 32'h1234});
        tick();
        #1 check_vec("add_left", {63'h0, ms_to_ws_valid}, 64'h0);

        // ld_b at 0x1003, response the cycle after entry
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b00001, 1'b1, 1'b1, 1'b1, 5'd7, 32'h1003, 16'h0, 1'b0, 32'h104);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check_vec("ldb_wait", {63'h0, ms_to_ws_valid}, 64'h0);
        check_vec("ldb_block", {63'h0, ms_fwd_bus[37]}, 64'h1);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h80FF_FF00;
        #1;
        check_vec("ldb_valid", {63'h0, ms_to_ws_valid}, 64'h1);
        check_vec("ldb_result", {32'h0, ms_to_ws_bus[63:32]}, 64'hFFFF_FF80);
        tick();
        data_sram_data_ok = 1'b0;
        #1 check_vec("ldb_left", {63'h0, ms_to_ws_valid}, 64'h0);

        // ld_hu at 0x2002, WB stalls on the response cycle and two more
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b01000, 1'b1, 1'b1, 1'b1, 5'd8, 32'h2002, 16'h0, 1'b0, 32'h108);
        tick();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'hBEEF_1234;
        #1 check_vec("ldhu_stall_allowin", {63'h0, ms_allowin}, 64'h0);
        tick();
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'hDEAD_DEAD;
        #1 check_vec("ldhu_buf", {32'h0, ms_to_ws_bus[63:32]}, 64'h0000_BEEF);
        tick();
        tick();
        ws_allowin = 1'b1;
        #1;
        check_vec("ldhu_valid", {63'h0, ms_to_ws_valid}, 64'h1);
        check_vec("ldhu_result", {32'h0, ms_to_ws_bus[63:32]}, 64'h0000_BEEF);
        tick();
        #1 check_vec("ldhu_single", {63'h0, ms_to_ws_valid}, 64'h0);

        // ld_w flushed before its response; next load must ignore the stale response
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b10000, 1'b1, 1'b1, 1'b1, 5'd9, 32'h3000, 16'h0, 1'b0, 32'h10C);
        tick();
        es_to_ms_valid = 1'b0; wb_ex = 1'b1;
        tick();
        wb_ex = 1'b0;
        #1 check_idle("cancel_flushed");
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b10000, 1'b1, 1'b1, 1'b1, 5'd10, 32'h4000, 16'h0, 1'b0, 32'h200);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        #1;
        check_vec("cancel_discard", {63'h0, ms_to_ws_valid}, 64'h0);
        check_vec("cancel_block", {63'h0, ms_fwd_bus[37]}, 64'h1);
        tick();
        data_sram_data_ok = 1'b0;
        #1 check_vec("cancel_wait", {63'h0, ms_to_ws_valid}, 64'h0);
        tick();
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h2222_2222;
        #1;
        check_vec("cancel_own_valid", {63'h0, ms_to_ws_valid}, 64'h1);
        check_vec("cancel_own_data", {ms_to_ws_bus[63:32], ms_to_ws_bus[31:0]}, 64'h2222_2222_0000_0200);
        tick();
        data_sram_data_ok = 1'b0;

        // ld_w with response and flush together, a new entry offered in the same cycle
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b10000, 1'b1, 1'b1, 1'b1, 5'd11, 32'h5000, 16'h0, 1'b0, 32'h300);
        tick();
        es_to_ms_bus = mk_bus(5'b0, 1'b0, 1'b0, 1'b1, 5'd12, 32'h77, 16'h0, 1'b0, 32'h304);
        data_sram_data_ok = 1'b1; wb_ex = 1'b1;
        tick();
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0; wb_ex = 1'b0;
        #1 check_idle("same_cycle_flush");
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b10000, 1'b1, 1'b1, 1'b1, 5'd13, 32'h6000, 16'h0, 1'b0, 32'h308);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h3333_3333;
        #1 check_vec("no_cancel", {31'h0, ms_to_ws_valid, ms_to_ws_bus[63:32]}, {31'h0, 1'b1, 32'h3333_3333});
        tick();
        data_sram_data_ok = 1'b0;

        // ALE exception: mem_ex up, forwarded write enable suppressed
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b0, 1'b0, 1'b0, 1'b1, 5'd14, 32'h1001, 16'h1 << EXC_ALE, 1'b0, 32'h400);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        check_vec("ale_mem_ex", {62'h0, mem_ex, mem_ertn}, 64'h2);
        check_vec("ale_ws", {47'h0, ms_to_ws_bus[179:164], ms_to_ws_bus[69]}, {47'h0, 16'h0200, 1'b0});
        tick();

        // reset in the middle of an ertn-flagged load
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(5'b10000, 1'b1, 1'b1, 1'b1, 5'd15, 32'h7000, 16'h0, 1'b1, 32'h500);
        tick();
        es_to_ms_valid = 1'b0;
        #1 check_vec("midload_ertn", {62'h0, mem_ertn, ms_fwd_bus[37]}, 64'h3);
        resetn = 1'b0;
        tick();
        #1 check_idle("midload_reset");
        resetn = 1'b1;
        tick();
        #1 check_idle("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: ES_MS_W, default 213, width of es_to_ms_bus.
REQ-002 Parameter: MS_WS_W, default 180, width of ms_to_ws_bus.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: resetn  input  1  synchronous, active-low reset.
REQ-005 Port: ws_allowin  input  1  WB stage can accept.
REQ-006 Port: ms_allowin  output  1  this stage can accept.
REQ-007 Port: es_to_ms_valid  input  1  EXE offers an instruction.
REQ-008 Port: es_to_ms_bus  input  ES_MS_W  EXE payload; field offsets from the shared package.
REQ-009 Port: ms_to_ws_valid  output  1  instruction offered to WB.
REQ-010 Port: ms_to_ws_bus  output  MS_WS_W  {exc vector, csr fields, gr_we, dest, final_result, pc}.
REQ-011 Port: data_sram_data_ok  input  1  read/write response for the single outstanding request.
REQ-012 Port: data_sram_rdata  input  32  read data, valid with data_ok.
REQ-013 Port: wb_ex, wb_ertn  input  1 each  flush from WB.
REQ-014 Port: mem_ex, mem_ertn  output  1 each  exception/ertn present in a valid MEM instruction.
REQ-015 Port: ms_fwd_bus  output  39  {fwd_we, fwd_block, dest[4:0], final_result[31:0]} for ID bypass.

Function
REQ-016 Latch es_to_ms_bus into the payload register when es_to_ms_valid && ms_allowin; ms_valid <= es_to_ms_valid when ms_allowin.
REQ-017 Consumed bus fields: is_req, ld_op{b,bu,h,hu,w}, res_from_mem, gr_we, dest, result[31:0], exception vector, ertn flag, pc.
REQ-018 ms_ready_go = !cancel && (!is_req || data_ok_seen || data_sram_data_ok).
REQ-019 ms_allowin = !ms_valid || (ms_ready_go && ws_allowin); ms_to_ws_valid = ms_valid && ms_ready_go.
REQ-020 When data_ok arrives for a valid instruction and ws_allowin=0, capture rdata into rdata_buf and set data_ok_seen; clear data_ok_seen when the instruction leaves to WB.
REQ-021 Load data source: data_ok_seen ? rdata_buf : data_sram_rdata.
REQ-022 Byte select by result[1:0]; ld_b sign-extends, ld_bu zero-extends; halfword select by result[1]; ld_h sign-extends, ld_hu zero-extends; ld_w passes 32 bits.
REQ-023 final_result = res_from_mem ? extracted load data : result.
REQ-024 gr_we forwarded to WB forced 0 when the exception vector is non-zero.
REQ-025 mem_ex = ms_valid && |exc_vector; mem_ertn = ms_valid && ertn flag; both combinational.
REQ-026 fwd_we = ms_valid && gr_we; fwd_block = ms_valid && res_from_mem && !ms_ready_go.
REQ-027 Flush: wb_ex|wb_ertn clears ms_valid next cycle, overriding any new entry.
REQ-028 Flush while is_req && !data_ok_seen && !data_sram_data_ok in the flush cycle sets cancel; the next data_ok is discarded and clears cancel.
REQ-029 While cancel=1, ms_ready_go=0; a newly entered instruction waits for its own data_ok after cancel clears.
REQ-030 Simultaneous data_ok and flush: response belongs to flushed instruction, cancel not set.
REQ-031 At most one outstanding data request; the stage never reorders responses.

Reset
REQ-032 resetn=0 at a clock edge: ms_valid=0, cancel=0, data_ok_seen=0, rdata_buf=0; payload register unreset.
REQ-033 Outputs during and after reset until first entry: ms_to_ws_valid=0, ms_allowin=1, mem_ex=0, mem_ertn=0, fwd_we=0, fwd_block=0.
REQ-034 Reset mid-transaction drops all state including cancel; responses after reset are not expected by the system.

Structure
REQ-035 Shared package holds ES_MS_W, MS_WS_W, bus field offsets, ld_op bit positions, exception vector width.
REQ-036 Load extraction is one combinational sub-module: mem_load_align (ld_op, addr[1:0], rdata -> data).

Verification
REQ-037 ld_b, result=0x1003, rdata=0x80FF_FF00, data_ok next cycle, ws_allowin=1 -> final_result 0xFFFF_FF80, one cycle after data_ok.
REQ-038 ld_hu, result=0x2002, rdata=0xBEEF_1234, ws_allowin=0 on data_ok, 1 three cycles later -> rdata_buf used, final_result 0x0000_BEEF, single handoff.
REQ-039 ld_w issued, wb_ex one cycle later before data_ok; next instruction enters; first data_ok discarded, second data_ok completes new instruction with its own rdata.
REQ-040 ld_w with data_ok and wb_ex same cycle -> ms_valid=0 next cycle, cancel stays 0.
REQ-041 Non-memory add, result=0x1234 -> ms_to_ws_valid same cycle as ms_valid, fwd_block=0, fwd_we=1, dest forwarded.
REQ-042 Entry with ALE exception bit set -> mem_ex=1 while valid, forwarded gr_we=0; resetn=0 mid-load -> all outputs at REQ-033 values next cycle.
